// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl
// Sequences a PLL through reset, lock acquisition and run. Accepts runtime
// divider/duty/phase reconfiguration requests, retries lock a bounded number
// of times and parks the PLL powered down when it cannot lock.
//
// Ports:
//    clk        system clock
//    rst        synchronous active-high reset
//    cfg_valid  reconfiguration request (held until accepted)
//    cfg_ready  controller can accept a request (RUN or FAIL)
//    cfg_odiv   requested output divider
//    cfg_duty   requested duty setting
//    cfg_phase  requested phase setting
//    pll_lock   PLL lock indicator, asynchronous to clk
//    pll_rst    PLL reset
//    pll_pwd    PLL power-down
//    dyn_odiv   applied output divider
//    dyn_duty   applied duty setting
//    dyn_phase  applied phase setting
//    locked     stable lock
//    busy       reset/lock sequence in progress
//    done       one-cycle pulse when stable lock is reached
//    err        one-cycle error pulse
//    err_code   0 none, 1 lock timeout, 2 bad configuration
//    lost_lock  one-cycle pulse when lock drops while running
module pll_reconfig_ctrl #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_STABLE  = 64,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int MAX_RETRY    = 3,
   parameter int DEF_ODIV     = 100,
   parameter int DEF_DUTY     = 100,
   parameter int DEF_PHASE    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [9:0]  cfg_odiv,
   input  logic [9:0]  cfg_duty,
   input  logic [12:0] cfg_phase,
   input  logic        pll_lock,
   output logic        pll_rst,
   output logic        pll_pwd,
   output logic [9:0]  dyn_odiv,
   output logic [9:0]  dyn_duty,
   output logic [12:0] dyn_phase,
   output logic        locked,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        lost_lock
);

   localparam int RW = (RST_CYCLES  > 1) ? $clog2(RST_CYCLES + 1)  : 1;
   localparam int SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE + 1) : 1;
   localparam logic [RW-1:0] RST_LAST     = RW'(RST_CYCLES - 1);
   localparam logic [SW-1:0] STABLE_DONE  = SW'(LOCK_STABLE);
   localparam logic [15:0]   TIMEOUT_DONE = 16'(LOCK_TIMEOUT);
   localparam logic [2:0]    RETRY_LIMIT  = 3'(MAX_RETRY);

   typedef enum logic [1:0] {ASSERT, WAIT_LOCK, RUN, FAIL} state_t;

   state_t         state_reg;
   logic           lock_meta_reg;
   logic           lock_s_reg;
   logic [RW-1:0]  rst_cnt_reg;
   logic [SW-1:0]  stable_cnt_reg;
   logic [15:0]    timeout_cnt_reg;
   logic [2:0]     retry_reg;

   logic [SW-1:0]  stable_next;
   logic [15:0]    timeout_next;
   logic [2:0]     retry_next;
   logic [10:0]    duty_max;
   logic           transfer;
   logic           cfg_ok;

   // Level outputs are a pure function of the state being entered, so they
   // are loaded together with the state register and stay glitch-free.
   // Order: {pll_rst, pll_pwd, locked, busy, cfg_ready}
   function automatic logic [4:0] flags_of(input state_t s);
      case (s)
         ASSERT:    flags_of = 5'b10010;
         WAIT_LOCK: flags_of = 5'b00010;
         RUN:       flags_of = 5'b00101;
         default:   flags_of = 5'b11001;
      endcase
   endfunction

   assign stable_next  = lock_s_reg ? stable_cnt_reg + SW'(1) : '0;
   assign timeout_next = timeout_cnt_reg + 16'd1;
   assign retry_next   = retry_reg + 3'd1;
   assign transfer     = cfg_valid & cfg_ready;

   // duty must lie in 1 .. 2*odiv-1; the 11-bit difference cannot wrap
   // because odiv==0 is rejected first.
   assign duty_max = {cfg_odiv, 1'b0} - 11'd1;
   assign cfg_ok   = (cfg_odiv != '0) && (cfg_duty != '0) &&
                     ({1'b0, cfg_duty} <= duty_max);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ASSERT;
         {pll_rst, pll_pwd, locked, busy, cfg_ready} <= flags_of(ASSERT);
         lock_meta_reg   <= 1'b0;
         lock_s_reg      <= 1'b0;
         rst_cnt_reg     <= '0;
         stable_cnt_reg  <= '0;
         timeout_cnt_reg <= '0;
         retry_reg       <= '0;
         dyn_odiv        <= 10'(DEF_ODIV);
         dyn_duty        <= 10'(DEF_DUTY);
         dyn_phase       <= 13'(DEF_PHASE);
         done            <= 1'b0;
         err             <= 1'b0;
         err_code        <= 2'd0;
         lost_lock       <= 1'b0;
      end else begin
         lock_meta_reg <= pll_lock;
         lock_s_reg    <= lock_meta_reg;
         done          <= 1'b0;
         err           <= 1'b0;
         lost_lock     <= 1'b0;

         // A good transfer (only possible in RUN/FAIL) overrides anything
         // else that happens this cycle, including a lock loss.
         if (transfer && cfg_ok) begin
            dyn_odiv        <= cfg_odiv;
            dyn_duty        <= cfg_duty;
            dyn_phase       <= cfg_phase;
            err_code        <= 2'd0;
            retry_reg       <= '0;
            state_reg       <= ASSERT;
            {pll_rst, pll_pwd, locked, busy, cfg_ready} <= flags_of(ASSERT);
            rst_cnt_reg     <= '0;
            stable_cnt_reg  <= '0;
            timeout_cnt_reg <= '0;
         end else begin
            // A rejected request only reports; the state logic below still
            // runs so a simultaneous lock loss is not missed.
            if (transfer) begin
               err      <= 1'b1;
               err_code <= 2'd2;
            end
            case (state_reg)
               ASSERT: begin
                  if (rst_cnt_reg == RST_LAST) begin
                     state_reg <= WAIT_LOCK;
                     {pll_rst, pll_pwd, locked, busy, cfg_ready} <= flags_of(WAIT_LOCK);
                  end else begin
                     rst_cnt_reg <= rst_cnt_reg + RW'(1);
                  end
               end
               WAIT_LOCK: begin
                  // Stable lock is tested first so it wins a tie with timeout.
                  if (stable_next == STABLE_DONE) begin
                     state_reg <= RUN;
                     {pll_rst, pll_pwd, locked, busy, cfg_ready} <= flags_of(RUN);
                     done      <= 1'b1;
                  end else if (timeout_next == TIMEOUT_DONE) begin
                     retry_reg <= retry_next;
                     if (retry_next < RETRY_LIMIT) begin
                        state_reg       <= ASSERT;
                        {pll_rst, pll_pwd, locked, busy, cfg_ready} <= flags_of(ASSERT);
                        rst_cnt_reg     <= '0;
                        stable_cnt_reg  <= '0;
                        timeout_cnt_reg <= '0;
                     end else begin
                        state_reg <= FAIL;
                        {pll_rst, pll_pwd, locked, busy, cfg_ready} <= flags_of(FAIL);
                        err       <= 1'b1;
                        err_code  <= 2'd1;
                     end
                  end else begin
                     stable_cnt_reg  <= stable_next;
                     timeout_cnt_reg <= timeout_next;
                  end
               end
               RUN: begin
                  if (!lock_s_reg) begin
                     lost_lock       <= 1'b1;
                     retry_reg       <= '0;
                     state_reg       <= ASSERT;
                     {pll_rst, pll_pwd, locked, busy, cfg_ready} <= flags_of(ASSERT);
                     rst_cnt_reg     <= '0;
                     stable_cnt_reg  <= '0;
                     timeout_cnt_reg <= '0;
                  end
               end
               default: begin
                  // FAIL is left only through a good transfer or rst.
               end
            endcase
         end
      end
   end

endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 Parameters (name, default, meaning): RST_CYCLES 16, pll_rst pulse length in clk cycles (min 1); LOCK_STABLE 64, consecutive synced-lock cycles needed to declare lock (min 1); LOCK_TIMEOUT 65535, max WAIT_LOCK cycles per attempt, 16-bit; MAX_RETRY 3, attempts before FAIL (1..7); DEF_ODIV 100, DEF_DUTY 100, DEF_PHASE 16, power-up divider settings.
REQ-002 Ports (name direction width meaning), clock and reset first: clk in 1 single system clock; rst in 1 synchronous active-high reset.
REQ-003 cfg_valid in 1 reconfig request; cfg_ready out 1 controller can accept; cfg_odiv in 10, cfg_duty in 10, cfg_phase in 13 requested settings.
REQ-004 pll_lock in 1 PLL lock, asynchronous to clk; pll_rst out 1 PLL reset; pll_pwd out 1 PLL power-down; dyn_odiv out 10, dyn_duty out 10, dyn_phase out 13 applied settings.
REQ-005 locked out 1 stable lock; busy out 1 sequence in progress; done out 1 one-cycle lock-achieved pulse; err out 1 one-cycle error pulse; err_code out 2 (0 none, 1 lock timeout, 2 bad cfg); lost_lock out 1 one-cycle lock-loss pulse.

Function
REQ-006 pll_lock SHALL pass a 2-flop synchronizer (lock_s) before any use; all outputs registered.
REQ-007 States: ASSERT, WAIT_LOCK, RUN, FAIL; reset entry state is ASSERT with retry count 0.
REQ-008 ASSERT: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK; timeout and stable counters cleared on entry.
REQ-009 WAIT_LOCK: pll_rst=0; stable counter increments while lock_s=1, clears to 0 when lock_s=0; reaching LOCK_STABLE -> RUN with done=1 for one cycle on the transition.
REQ-010 WAIT_LOCK timeout counter increments every cycle; reaching LOCK_TIMEOUT without stable lock -> retry+1; if retry < MAX_RETRY then ASSERT, else FAIL with err=1, err_code=1.
REQ-011 Stable-lock completion in the same cycle as timeout SHALL win (RUN, no error).
REQ-012 RUN: locked=1; lock_s falling to 0 -> lost_lock=1 one cycle, locked=0, retry cleared, ASSERT (same settings).
REQ-013 FAIL: pll_rst held 1, locked=0; stays until an accepted cfg transfer or rst.
REQ-014 cfg_ready=1 only in RUN and FAIL; transfer occurs when cfg_valid&cfg_ready; cfg_valid in other states is held off, not dropped.
REQ-015 Valid cfg: cfg_odiv>=1 and 1<=cfg_duty<=2*cfg_odiv-1 (11-bit compare). Valid transfer: latch into dyn_* next cycle, err_code=0, retry cleared, -> ASSERT.
REQ-016 Invalid transfer: dyn_* unchanged, err=1, err_code=2, state unchanged (RUN stays RUN, FAIL stays FAIL).
REQ-017 Lock-loss and valid transfer in the same RUN cycle: transfer wins; no lost_lock pulse.
REQ-018 busy=1 in ASSERT and WAIT_LOCK, 0 in RUN and FAIL.
REQ-019 pll_pwd SHALL be 1 only in FAIL, 0 elsewhere.
REQ-020 err_code holds its value until next accepted transfer or rst.

Reset
REQ-021 On rst: state ASSERT (RST_CYCLES count restarts), pll_rst=1, pll_pwd=0, dyn_odiv=DEF_ODIV, dyn_duty=DEF_DUTY, dyn_phase=DEF_PHASE, locked=0, busy=1, cfg_ready=0, done=err=lost_lock=0, err_code=0, synchronizer flops 0.
REQ-022 rst asserted mid-sequence (any state) SHALL abort immediately and restart power-up with default settings; latched cfg discarded.

Verification
REQ-023 Power-up, pll_lock rises 40 cycles after rst release -> pll_rst high cycles 0..15, done pulse at 40+2+64 cycles (±1), locked=1, dyn_odiv=100.
REQ-024 In RUN, transfer odiv=200 duty=200 phase=16 -> cfg_ready low next cycle, dyn_odiv=200, pll_rst high 16 cycles, lock reacquired -> done, locked=1.
REQ-025 pll_lock held 0 with LOCK_TIMEOUT=100 -> three ASSERT/WAIT_LOCK attempts, then FAIL, err pulse, err_code=1, pll_pwd=1; then valid cfg -> ASSERT, err_code=0.
REQ-026 Transfer odiv=10 duty=20 in RUN -> err pulse, err_code=2, dyn_* unchanged, state RUN, locked stays 1.
REQ-027 pll_lock drops 1 cycle in RUN -> lost_lock pulse, pll_rst 16 cycles, relock -> done; lock glitch mid-WAIT_LOCK resets stable count (done delayed by full LOCK_STABLE).
REQ-028 rst pulsed during WAIT_LOCK after reconfig to odiv=200 -> dyn_odiv=100, pll_rst=1 for 16 cycles, normal power-up follows.
